// File: rtl/row_encoder_np.sv
// Row encoder: packs NPIX pixels per word, suppresses repeated rows with timestamp and
// wrap words, and queues words in an output FIFO. Define ROW_ENC_DROP_CNT_EN for drop_cnt.
module row_encoder_np #(
    parameter int NPIX       = 5,
    parameter int PIX_W      = 3,
    parameter int TS_W       = 45,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        data_valid,
    input  logic [NPIX*PIX_W-1:0]       pixel_in,
    input  logic [TS_W-1:0]             tik_tok,
    output logic [NPIX*PIX_W:0]         out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow
`ifdef ROW_ENC_DROP_CNT_EN
    ,
    output logic [15:0]                 drop_cnt
`endif
);

    localparam int PW     = NPIX * PIX_W;
    localparam int WORD_W = PW + 1;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int LW     = AW + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        SUPPRESS = 2'd2
    } state_t;

    state_t             state_q;
    logic               data_valid_q;
    logic               data_pend_q;
    logic               wrap_pend_q;
    logic [PW-1:0]      row_q;

    logic               rise;
    logic               same_row;
    logic               ts_push;
    logic               new_push;
    logic               wrap_push;
    logic               push_en;
    logic [PW-1:0]      field;
    logic [PW-1:0]      ts_field;
    logic [WORD_W-1:0]  push_word;

    logic [WORD_W-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_q;
    logic [AW-1:0]      rd_q;
    logic [LW-1:0]      count_q;
    logic               overflow_q;
    logic               pop;
    logic               full;
    logic               accept;
    logic               drop;
    logic               unused_ok;

    // Only the low PW timer bits form the timestamp field.
    assign unused_ok = ^tik_tok;

    always_comb begin
        rise      = data_valid & ~data_valid_q;
        field     = tik_tok[PW-1:0];
        ts_field  = (field == '0) ? PW'(1) : field;
        same_row  = (pixel_in == row_q);
        ts_push   = rise && (state_q == SUPPRESS) && !same_row;
        new_push  = rise && ((state_q == IDLE) || ((state_q == ACTIVE) && !same_row));
        wrap_push = 1'b0;
        push_en   = 1'b1;
        push_word = '0;
        // One push per cycle: TS, then the deferred DATA, then new DATA, then WRAP.
        if (ts_push) begin
            push_word = {1'b1, ts_field};
        end else if (data_pend_q) begin
            push_word = {1'b0, row_q};
        end else if (new_push) begin
            push_word = {1'b0, pixel_in};
        end else if (wrap_pend_q) begin
            push_word = {1'b1, {PW{1'b0}}};
            wrap_push = 1'b1;
        end else begin
            push_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            row_q        <= '0;
            data_valid_q <= 1'b0;
            data_pend_q  <= 1'b0;
            wrap_pend_q  <= 1'b0;
        end else begin
            data_valid_q <= data_valid;
            data_pend_q  <= ts_push;
            // A new rollover wins over clearing, so back-to-back rollovers merge.
            wrap_pend_q  <= (wrap_pend_q & ~wrap_push) | ((&field) && (state_q != IDLE));
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        row_q   <= pixel_in;
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (rise) begin
                        if (same_row) begin
                            state_q <= SUPPRESS;
                        end else begin
                            row_q <= pixel_in;
                        end
                    end
                end
                SUPPRESS: begin
                    if (rise && !same_row) begin
                        row_q   <= pixel_in;
                        state_q <= ACTIVE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid  = (count_q != '0);
    assign out_data   = out_valid ? mem_q[rd_q] : '0;
    assign fifo_level = count_q;
    assign overflow   = overflow_q;
    assign pop        = out_valid & out_ready;
    assign full       = (count_q == LW'(FIFO_DEPTH));
    assign accept     = push_en & (~full | pop);
    assign drop       = push_en & full & ~pop;

    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            mem_q[wr_q] <= push_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) begin
                wr_q <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            if (accept && !pop) begin
                count_q <= count_q + LW'(1);
            end else if (!accept && pop) begin
                count_q <= count_q - LW'(1);
            end
            overflow_q <= overflow_q | drop;
        end
    end

`ifdef ROW_ENC_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_row_encoder_np.sv
// Bench for row_encoder_np: a run-length style model with a queue-based FIFO checks
// every cycle, plus literal word checks and a second NPIX=8/PIX_W=2 instance.
module tb_row_encoder_np;

    localparam int DEPTH = 8;
    localparam logic [44:0] IDLE_TT = 45'h1F00_0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_valid;
    logic [14:0] pixel_in;
    logic [44:0] tik_tok;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  fifo_level;
    logic        overflow;

    logic        rst2;
    logic        dv2;
    logic [15:0] pix2;
    logic [19:0] tt2;
    logic [16:0] out_data2;
    logic        valid2;
    logic        ready2;
    logic [3:0]  level2;
    logic        ovf2;

`ifdef ROW_ENC_DROP_CNT_EN
    logic [15:0] drop_cnt;
    logic [15:0] drop_cnt2;
`endif

    always #5 clk = ~clk;

    row_encoder_np dut (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .pixel_in   (pixel_in),
        .tik_tok    (tik_tok),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow)
`ifdef ROW_ENC_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    row_encoder_np #(.NPIX(8), .PIX_W(2), .TS_W(20), .FIFO_DEPTH(8)) dut2 (
        .clk        (clk),
        .rst        (rst2),
        .data_valid (dv2),
        .pixel_in   (pix2),
        .tik_tok    (tt2),
        .out_data   (out_data2),
        .out_valid  (valid2),
        .out_ready  (ready2),
        .fifo_level (level2),
        .overflow   (ovf2)
`ifdef ROW_ENC_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt2)
`endif
    );

    int passCount  = 0;
    int checkCount = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: actual %h expected %h at %0t", name, actual, expected, $time);
        end else begin
            passCount++;
        end
    endtask

    // Model state: a row run is tracked as "last row + number of repeats seen".
    bit          mStarted = 1'b0;
    bit          mActive, mDefer, mWrap, mPrev, mOvf;
    bit          mRise, mHasTs, mHasNew, mPush, mWrapTaken, mPop, mFull;
    logic [14:0] mRow, mF;
    logic [15:0] mWord;
    int          mRepeats, mDrops;
    logic [15:0] mq[$];
    logic [15:0] mLog[$];
    logic [15:0] dLog[$];

    always @(posedge clk) begin
        if (rst) begin
            mStarted = 1'b1;
            mActive  = 1'b0;
            mDefer   = 1'b0;
            mWrap    = 1'b0;
            mPrev    = 1'b0;
            mOvf     = 1'b0;
            mRow     = '0;
            mRepeats = 0;
            mDrops   = 0;
            mq.delete();
        end else if (mStarted) begin
            mF      = tik_tok[14:0];
            mRise   = data_valid && !mPrev;
            mHasTs  = 1'b0;
            mHasNew = 1'b0;
            if (mRise) begin
                if (!mActive) mHasNew = 1'b1;
                else if (pixel_in == mRow) mRepeats++;
                else if (mRepeats > 0) mHasTs = 1'b1;
                else mHasNew = 1'b1;
            end
            mPush      = 1'b1;
            mWrapTaken = 1'b0;
            mWord      = 16'h0;
            if (mHasTs) mWord = {1'b1, (mF == 15'd0) ? 15'd1 : mF};
            else if (mDefer) mWord = {1'b0, mRow};
            else if (mHasNew) mWord = {1'b0, pixel_in};
            else if (mWrap) begin
                mWord      = 16'h8000;
                mWrapTaken = 1'b1;
            end else mPush = 1'b0;
            mWrap  = (mWrap && !mWrapTaken) || ((mF == 15'h7FFF) && mActive);
            mDefer = mHasTs;
            if (mHasTs || mHasNew) begin
                mRow     = pixel_in;
                mRepeats = 0;
                mActive  = 1'b1;
            end
            mPop  = (mq.size() != 0) && out_ready;
            mFull = (mq.size() == DEPTH);
            if (mPop) begin
                mLog.push_back(mq[0]);
                void'(mq.pop_front());
            end
            if (mPush) begin
                if (mFull && !mPop) begin
                    mOvf = 1'b1;
                    if (mDrops < 65535) mDrops++;
                end else begin
                    mq.push_back(mWord);
                end
            end
            mPrev = data_valid;
        end
    end

    always @(negedge clk) begin
        if (mStarted) begin
            checkOutput("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            checkOutput("out_data", 32'(out_data), 32'((mq.size() != 0) ? mq[0] : 16'h0));
            checkOutput("fifo_level", 32'(fifo_level), 32'(mq.size()));
            checkOutput("overflow", 32'(overflow), 32'(mOvf));
`ifdef ROW_ENC_DROP_CNT_EN
            checkOutput("drop_cnt", 32'(drop_cnt), 32'(mDrops));
`endif
            if (!rst && out_valid && out_ready) dLog.push_back(out_data);
        end
    end

    task automatic applyStimulus(input bit r, input bit dv, input logic [14:0] pix,
                                 input logic [44:0] tt, input bit rdy);
        @(posedge clk);
        #1;
        rst        = r;
        data_valid = dv;
        pixel_in   = pix;
        tik_tok    = tt;
        out_ready  = rdy;
    endtask

    task automatic sendRow(input logic [14:0] pix, input logic [44:0] tt, input bit rdy);
        applyStimulus(1'b0, 1'b1, pix, tt, rdy);
        applyStimulus(1'b0, 1'b0, pix, IDLE_TT, rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 15'h0, IDLE_TT, rdy);
    endtask

    task automatic expectWord(input int idx, input logic [15:0] lit);
        logic [15:0] d;
        logic [15:0] m;
        d = (idx < dLog.size()) ? dLog[idx] : 16'hxxxx;
        m = (idx < mLog.size()) ? mLog[idx] : 16'hxxxx;
        checkOutput($sformatf("dut word %0d", idx), 32'(d), 32'(lit));
        checkOutput($sformatf("model word %0d", idx), 32'(m), 32'(lit));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; data_valid = 1'b0; pixel_in = '0; tik_tok = IDLE_TT; out_ready = 1'b1;
        rst2 = 1'b1; dv2 = 1'b0; pix2 = '0; tt2 = 20'h00010; ready2 = 1'b0;
        applyStimulus(1'b1, 1'b0, 15'h0, IDLE_TT, 1'b1);
        applyStimulus(1'b0, 1'b0, 15'h0, IDLE_TT, 1'b1);
        idle(2, 1'b1);

        // Two distinct rows straight through.
        sendRow(15'h1234, IDLE_TT, 1'b1);
        sendRow(15'h5678, IDLE_TT, 1'b1);
        idle(3, 1'b1);

        // Suppressed run broken at F=0x0123.
        sendRow(15'h0AAA, IDLE_TT, 1'b1);
        sendRow(15'h0AAA, IDLE_TT, 1'b1);
        sendRow(15'h0AAA, IDLE_TT, 1'b1);
        sendRow(15'h0BBB, 45'h0A00_0000_0123, 1'b1);
        idle(3, 1'b1);

        // Break at F=0, then a rollover while active.
        sendRow(15'h0BBB, IDLE_TT, 1'b1);
        sendRow(15'h0CCC, 45'h0800_0000_0000, 1'b1);
        applyStimulus(1'b0, 1'b0, 15'h0, 45'h0000_0000_7FFF, 1'b1);
        idle(4, 1'b1);
        checkOutput("log size before reset", 32'(dLog.size()), 32'd8);

        // Rollover while idle after reset pushes nothing.
        applyStimulus(1'b1, 1'b0, 15'h0, IDLE_TT, 1'b1);
        applyStimulus(1'b0, 1'b0, 15'h0, 45'h0000_0000_7FFF, 1'b1);
        applyStimulus(1'b0, 1'b0, 15'h0, 45'h0000_0000_7FFF, 1'b1);
        idle(2, 1'b1);
        @(negedge clk);
        checkOutput("idle wrap level", 32'(fifo_level), 32'd0);
        checkOutput("idle wrap log size", 32'(dLog.size()), 32'd8);

        // Fill past depth with the consumer stalled.
        for (int k = 1; k <= 10; k++) sendRow(15'h0100 + 15'(k), IDLE_TT, 1'b0);
        @(negedge clk);
        checkOutput("full level", 32'(fifo_level), 32'd8);
        checkOutput("full overflow", 32'(overflow), 32'd1);
`ifdef ROW_ENC_DROP_CNT_EN
        checkOutput("drop count", 32'(drop_cnt), 32'd2);
`endif
        idle(10, 1'b1);

        // TS break coinciding with a rollover.
        applyStimulus(1'b1, 1'b0, 15'h0, IDLE_TT, 1'b1);
        applyStimulus(1'b0, 1'b0, 15'h0, IDLE_TT, 1'b1);
        sendRow(15'h0111, IDLE_TT, 1'b1);
        sendRow(15'h0111, IDLE_TT, 1'b1);
        sendRow(15'h0222, 45'h0000_0000_7FFF, 1'b1);
        idle(5, 1'b1);

        expectWord(0, 16'h1234);
        expectWord(1, 16'h5678);
        expectWord(2, 16'h0AAA);
        expectWord(3, 16'h8123);
        expectWord(4, 16'h0BBB);
        expectWord(5, 16'h8001);
        expectWord(6, 16'h0CCC);
        expectWord(7, 16'h8000);
        for (int k = 1; k <= 8; k++) expectWord(7 + k, 16'h0100 + 16'(k));
        expectWord(16, 16'h0111);
        expectWord(17, 16'hFFFF);
        expectWord(18, 16'h0222);
        expectWord(19, 16'h8000);
        checkOutput("total words", 32'(dLog.size()), 32'd20);

        // Wide instance: all-ones row, reset mid-stream, re-entry from idle.
        @(posedge clk); #1; rst2 = 1'b0; dv2 = 1'b1; pix2 = 16'hFFFF;
        @(posedge clk); #1; dv2 = 1'b0;
        @(negedge clk);
        checkOutput("wide data", 32'(out_data2), 32'h0FFFF);
        checkOutput("wide valid", 32'(valid2), 32'd1);
        checkOutput("wide level", 32'(level2), 32'd1);
        @(posedge clk); #1; rst2 = 1'b1;
        @(posedge clk); #1; rst2 = 1'b0;
        @(negedge clk);
        checkOutput("wide reset valid", 32'(valid2), 32'd0);
        checkOutput("wide reset level", 32'(level2), 32'd0);
        checkOutput("wide reset data", 32'(out_data2), 32'd0);
        checkOutput("wide reset overflow", 32'(ovf2), 32'd0);
        @(posedge clk); #1; dv2 = 1'b1; pix2 = 16'hFFFF;
        @(posedge clk); #1; dv2 = 1'b0;
        @(negedge clk);
        checkOutput("wide reentry data", 32'(out_data2), 32'h0FFFF);
        checkOutput("wide reentry level", 32'(level2), 32'd1);

        idle(2, 1'b1);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
